payment_collector: RTL and testbench

Sequential payment stage that sits directly downstream of the tariff selection logic. It latches the `ValueToPay` amount produced for the selected client and duration, then accepts coins until the amount is covered. It reports the outstanding balance, a one-cycle paid pulse and the change due, and refunds the accumulated credit on cancel. All amounts are integer currency units.

---
 rtl/payment_pkg.sv | 25 ++
 rtl/payment_collector_coin_decoder.sv | 21 ++
 rtl/payment_collector.sv | 136 +++++++++++++
 tb/tb_payment_collector.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/payment_pkg.sv
// Shared types and constants for the payment stage: FSM states, coin codes and amount widths.
package payment_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2,
        ST_REFUND  = 2'd3
    } state_t;

    localparam int PRICE_W    = 5;
    localparam int CREDIT_W   = 6;
    localparam int CHANGE_W   = 3;
    localparam int COIN_VAL_W = 3;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_5    = 2'b11;

    localparam logic [COIN_VAL_W-1:0] COIN_1_VAL = 3'd1;
    localparam logic [COIN_VAL_W-1:0] COIN_2_VAL = 3'd2;
    localparam logic [COIN_VAL_W-1:0] COIN_5_VAL = 3'd5;

endpackage

// File: rtl/payment_collector_coin_decoder.sv
// Combinational coin code to unit value decoder; code 00 decodes as not valid.
module coin_decoder
    import payment_pkg::*;
(
    input  logic [1:0]            code,
    output logic [COIN_VAL_W-1:0] value,
    output logic                  valid
);

    always_comb begin
        value = '0;
        valid = 1'b0;
        case (code)
            COIN_1: begin value = COIN_1_VAL; valid = 1'b1; end
            COIN_2: begin value = COIN_2_VAL; valid = 1'b1; end
            COIN_5: begin value = COIN_5_VAL; valid = 1'b1; end
            default: begin value = '0; valid = 1'b0; end
        endcase
    end

endmodule

// File: rtl/payment_collector.sv
// Latches a price on Start, accumulates coins until covered, then pulses Paid/Change or Refund on cancel.
// All outputs registered, one cycle after the causing edge; PAYMENT_TIMEOUT_EN adds an idle-cycle auto-cancel.
module payment_collector
    import payment_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                Start,
    input  logic [PRICE_W-1:0]  ValueToPay,
    input  logic                CoinValid,
    input  logic [1:0]          CoinCode,
    input  logic                Cancel,
    output logic                Busy,
    output logic [PRICE_W-1:0]  Due,
    output logic                Paid,
    output logic [CHANGE_W-1:0] Change,
    output logic [PRICE_W-1:0]  Refund,
    output logic                RefundValid,
    output logic                CoinReject
);

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                state;
    logic [PRICE_W-1:0]    price;
    logic [CREDIT_W-1:0]   credit;
    logic [COIN_VAL_W-1:0] coin_val;
    logic                  coin_code_ok;
    logic                  coin_acc;
    logic [CREDIT_W-1:0]   credit_n;
    logic [PRICE_W-1:0]    due_n;
    logic [CHANGE_W-1:0]   change_n;
    logic                  timeout;

    coin_decoder u_coin_decoder (
        .code  (CoinCode),
        .value (coin_val),
        .valid (coin_code_ok)
    );

    assign coin_acc = CoinValid && coin_code_ok && (state == ST_COLLECT);
    assign credit_n = coin_acc ? credit + {{(CREDIT_W-COIN_VAL_W){1'b0}}, coin_val} : credit;
    // credit_n < price when due_n is used, and credit_n - price <= 4 when change_n is used,
    // so the narrowed arithmetic is exact.
    assign due_n    = price - credit_n[PRICE_W-1:0];
    assign change_n = credit_n[CHANGE_W-1:0] - price[CHANGE_W-1:0];

`ifdef PAYMENT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] idle_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idle_cnt <= '0;
        end else if (state != ST_COLLECT || coin_acc) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end

    assign timeout = (state == ST_COLLECT) && !coin_acc && (idle_cnt == CNT_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= ST_IDLE;
            price       <= '0;
            credit      <= '0;
            Busy        <= 1'b0;
            Due         <= '0;
            Paid        <= 1'b0;
            Change      <= '0;
            Refund      <= '0;
            RefundValid <= 1'b0;
            CoinReject  <= 1'b0;
        end else begin
            Paid        <= 1'b0;
            Change      <= '0;
            Refund      <= '0;
            RefundValid <= 1'b0;
            CoinReject  <= CoinValid && !coin_acc;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        price  <= ValueToPay;
                        credit <= '0;
                        if (ValueToPay == '0) begin
                            state <= ST_DONE;
                            Paid  <= 1'b1;
                        end else begin
                            state <= ST_COLLECT;
                            Busy  <= 1'b1;
                            Due   <= ValueToPay;
                        end
                    end
                end
                ST_COLLECT: begin
                    credit <= credit_n;
                    // A completing coin wins over a simultaneous cancel or timeout.
                    if (credit_n >= {1'b0, price}) begin
                        state  <= ST_DONE;
                        Paid   <= 1'b1;
                        Change <= change_n;
                        Busy   <= 1'b0;
                        Due    <= '0;
                    end else if (Cancel || timeout) begin
                        state       <= ST_REFUND;
                        RefundValid <= 1'b1;
                        Refund      <= credit_n[PRICE_W-1:0];
                        Busy        <= 1'b0;
                        Due         <= '0;
                    end else begin
                        Due <= due_n;
                    end
                end
                ST_DONE: begin
                    credit <= '0;
                    state  <= ST_IDLE;
                end
                default: begin
                    credit <= '0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_payment_collector.sv
// Self-checking bench for payment_collector: directed scenarios plus a randomized run against a transaction-level model.
module tb_payment_collector;

    localparam int TB_TIMEOUT = 20;
`ifdef PAYMENT_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Start = 1'b0;
    logic [4:0] ValueToPay = '0;
    logic       CoinValid = 1'b0;
    logic [1:0] CoinCode = '0;
    logic       Cancel = 1'b0;
    logic       Busy;
    logic [4:0] Due;
    logic       Paid;
    logic [2:0] Change;
    logic [4:0] Refund;
    logic       RefundValid;
    logic       CoinReject;

    payment_collector #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Start       (Start),
        .ValueToPay  (ValueToPay),
        .CoinValid   (CoinValid),
        .CoinCode    (CoinCode),
        .Cancel      (Cancel),
        .Busy        (Busy),
        .Due         (Due),
        .Paid        (Paid),
        .Change      (Change),
        .Refund      (Refund),
        .RefundValid (RefundValid),
        .CoinReject  (CoinReject)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a session holds the amount owed and the credit paid in so far.
    bit m_busy   = 1'b0;
    bit m_pulse  = 1'b0;
    int m_price  = 0;
    int m_credit = 0;
    int m_idle   = 0;
    logic       e_busy = 1'b0;
    logic [4:0] e_due = '0;
    logic       e_paid = 1'b0;
    logic [2:0] e_change = '0;
    logic [4:0] e_refund = '0;
    logic       e_rv = 1'b0;
    logic       e_reject = 1'b0;

    function automatic int coin_units(input logic [1:0] cc);
        case (cc)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 5;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_pulse = 1'b0; m_price = 0; m_credit = 0; m_idle = 0;
        e_busy = 1'b0; e_due = '0; e_paid = 1'b0; e_change = '0;
        e_refund = '0; e_rv = 1'b0; e_reject = 1'b0;
    endtask

    // Drives one cycle of inputs, advances the model across the edge, returns 1 time unit after it.
    task automatic drive(input logic st, input logic [4:0] vtp, input logic cv,
                         input logic [1:0] cc, input logic cn);
        int units;
        Start = st; ValueToPay = vtp; CoinValid = cv; CoinCode = cc; Cancel = cn;
        @(posedge Clk);
        units = coin_units(cc);
        e_paid = 1'b0; e_change = '0; e_rv = 1'b0; e_refund = '0;
        e_reject = cv && !(m_busy && units > 0);
        if (m_busy) begin
            if (cv && units > 0) begin
                m_credit = m_credit + units;
                m_idle = 0;
            end else begin
                m_idle = m_idle + 1;
            end
            if (m_credit >= m_price) begin
                m_busy = 1'b0;
                e_paid = 1'b1;
                e_change = 3'(m_credit - m_price);
            end else if (cn || (TIMEOUT_ON && m_idle >= TB_TIMEOUT)) begin
                m_busy = 1'b0;
                e_rv = 1'b1;
                e_refund = 5'(m_credit);
            end
        end else if (!m_pulse && st) begin
            m_price = int'(vtp);
            m_credit = 0;
            m_idle = 0;
            if (vtp == 5'd0) e_paid = 1'b1;
            else m_busy = 1'b1;
        end
        m_pulse = e_paid || e_rv;
        e_busy = m_busy;
        e_due = m_busy ? 5'(m_price - m_credit) : 5'd0;
        #1;
        Start = 1'b0; CoinValid = 1'b0; Cancel = 1'b0;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({Busy, Due, Paid, Change, Refund, RefundValid, CoinReject} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h want 0", {Busy, Due, Paid, Change, Refund, RefundValid, CoinReject});
        end
        #9 Reset_n = 1'b1;
        model_reset();
        idle_cycle();
        n_checks++;
        if ({Busy, Due, Paid, RefundValid, CoinReject} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_release_idle got %h want 0", {Busy, Due, Paid, RefundValid, CoinReject});
        end
    endtask

    task automatic test_exact_pay();
        drive(1'b1, 5'd7, 1'b0, 2'b00, 1'b0);
        n_checks++;
        if (Busy !== 1'b1 || Due !== 5'd7) begin
            n_fail++; $display("FAIL exact_start busy=%b due=%0d want busy=1 due=7", Busy, Due);
        end
        drive(1'b0, 5'd0, 1'b1, 2'b11, 1'b0);
        n_checks++;
        if (Due !== 5'd2 || Paid !== 1'b0) begin
            n_fail++; $display("FAIL exact_coin5 due=%0d paid=%b want due=2 paid=0", Due, Paid);
        end
        drive(1'b0, 5'd0, 1'b1, 2'b10, 1'b0);
        n_checks++;
        if (Paid !== 1'b1 || Change !== 3'd0 || Busy !== 1'b0 || Due !== 5'd0) begin
            n_fail++; $display("FAIL exact_paid paid=%b change=%0d busy=%b due=%0d want 1/0/0/0", Paid, Change, Busy, Due);
        end
        idle_cycle();
        n_checks++;
        if (Paid !== 1'b0) begin
            n_fail++; $display("FAIL exact_paid_one_cycle paid=%b want 0", Paid);
        end
    endtask

    task automatic test_change();
        drive(1'b1, 5'd3, 1'b0, 2'b00, 1'b0);
        drive(1'b0, 5'd0, 1'b1, 2'b11, 1'b0);
        n_checks++;
        if (Paid !== 1'b1 || Change !== 3'd2) begin
            n_fail++; $display("FAIL change_paid paid=%b change=%0d want paid=1 change=2", Paid, Change);
        end
        idle_cycle();
        n_checks++;
        if (Busy !== 1'b0 || Paid !== 1'b0 || Change !== 3'd0) begin
            n_fail++; $display("FAIL change_after busy=%b paid=%b change=%0d want 0/0/0", Busy, Paid, Change);
        end
    endtask

    task automatic test_cancel_with_coin();
        drive(1'b1, 5'd10, 1'b0, 2'b00, 1'b0);
        drive(1'b0, 5'd0, 1'b1, 2'b10, 1'b0);
        drive(1'b0, 5'd0, 1'b1, 2'b10, 1'b0);
        drive(1'b0, 5'd0, 1'b1, 2'b01, 1'b1);
        n_checks++;
        if (RefundValid !== 1'b1 || Refund !== 5'd5 || Busy !== 1'b0 || Due !== 5'd0) begin
            n_fail++; $display("FAIL cancel_refund rv=%b refund=%0d busy=%b due=%0d want 1/5/0/0", RefundValid, Refund, Busy, Due);
        end
        idle_cycle();
        n_checks++;
        if (RefundValid !== 1'b0 || Refund !== 5'd0) begin
            n_fail++; $display("FAIL cancel_one_cycle rv=%b refund=%0d want 0/0", RefundValid, Refund);
        end
    endtask

    task automatic test_reject();
        drive(1'b0, 5'd0, 1'b1, 2'b01, 1'b1);
        n_checks++;
        if (CoinReject !== 1'b1 || Busy !== 1'b0 || RefundValid !== 1'b0) begin
            n_fail++; $display("FAIL reject_idle rej=%b busy=%b rv=%b want 1/0/0", CoinReject, Busy, RefundValid);
        end
        idle_cycle();
        n_checks++;
        if (CoinReject !== 1'b0) begin
            n_fail++; $display("FAIL reject_one_cycle rej=%b want 0", CoinReject);
        end
        drive(1'b1, 5'd6, 1'b0, 2'b00, 1'b0);
        drive(1'b0, 5'd0, 1'b1, 2'b00, 1'b0);
        n_checks++;
        if (CoinReject !== 1'b1 || Due !== 5'd6) begin
            n_fail++; $display("FAIL reject_code00 rej=%b due=%0d want 1/6", CoinReject, Due);
        end
        drive(1'b1, 5'd20, 1'b0, 2'b00, 1'b0);
        n_checks++;
        if (Due !== 5'd6 || Busy !== 1'b1 || CoinReject !== 1'b0) begin
            n_fail++; $display("FAIL start_while_busy due=%0d busy=%b rej=%b want 6/1/0", Due, Busy, CoinReject);
        end
        drive(1'b0, 5'd0, 1'b0, 2'b00, 1'b1);
        n_checks++;
        if (RefundValid !== 1'b1 || Refund !== 5'd0) begin
            n_fail++; $display("FAIL reject_empty_refund rv=%b refund=%0d want 1/0", RefundValid, Refund);
        end
        idle_cycle();
    endtask

    task automatic test_zero_price();
        drive(1'b1, 5'd0, 1'b0, 2'b00, 1'b0);
        n_checks++;
        if (Paid !== 1'b1 || Change !== 3'd0 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_paid paid=%b change=%0d busy=%b want 1/0/0", Paid, Change, Busy);
        end
        idle_cycle();
        n_checks++;
        if (Paid !== 1'b0 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_after paid=%b busy=%b want 0/0", Paid, Busy);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 5'd2, 1'b0, 2'b00, 1'b0);
        drive(1'b0, 5'd0, 1'b1, 2'b10, 1'b0);
        // Start during the Paid cycle must be ignored.
        drive(1'b1, 5'd9, 1'b0, 2'b00, 1'b0);
        n_checks++;
        if (Busy !== 1'b0 || Due !== 5'd0) begin
            n_fail++; $display("FAIL start_during_paid busy=%b due=%0d want 0/0", Busy, Due);
        end
        drive(1'b1, 5'd4, 1'b0, 2'b00, 1'b0);
        n_checks++;
        if (Busy !== 1'b1 || Due !== 5'd4) begin
            n_fail++; $display("FAIL start_first_idle busy=%b due=%0d want 1/4", Busy, Due);
        end
        drive(1'b0, 5'd0, 1'b0, 2'b00, 1'b1);
        idle_cycle();
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        drive(1'b1, 5'd10, 1'b0, 2'b00, 1'b0);
        drive(1'b0, 5'd0, 1'b1, 2'b01, 1'b0);
        for (int i = 0; i < TB_TIMEOUT - 1; i++) begin
            idle_cycle();
            if (RefundValid !== 1'b0 || Busy !== 1'b1) early++;
        end
        n_checks++;
        if (early != 0) begin
            n_fail++; $display("FAIL timeout_early bad_cycles=%0d want 0", early);
        end
        idle_cycle();
        n_checks++;
        if (RefundValid !== 1'b1 || Refund !== 5'd1 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_refund rv=%b refund=%0d busy=%b want 1/1/0", RefundValid, Refund, Busy);
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 5'd9, 1'b0, 2'b00, 1'b0);
        drive(1'b0, 5'd0, 1'b1, 2'b10, 1'b0);
        n_checks++;
        if (Due !== 5'd7 || Busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_before_reset due=%0d busy=%b want 7/1", Due, Busy);
        end
        #2 Reset_n = 1'b0;
        #1;
        n_checks++;
        if ({Busy, Due, Paid, Change, Refund, RefundValid, CoinReject} !== 17'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs got %h want 0", {Busy, Due, Paid, Change, Refund, RefundValid, CoinReject});
        end
        model_reset();
        @(negedge Clk);
        #1 Reset_n = 1'b1;
        drive(1'b1, 5'd1, 1'b0, 2'b00, 1'b0);
        drive(1'b0, 5'd0, 1'b1, 2'b01, 1'b0);
        n_checks++;
        if (Paid !== 1'b1 || Change !== 3'd0) begin
            n_fail++; $display("FAIL mid_after_reset paid=%b change=%0d want 1/0", Paid, Change);
        end
        idle_cycle();
    endtask

    task automatic test_random();
        logic st, cv, cn;
        logic [4:0] vtp;
        logic [1:0] cc;
        for (int i = 0; i < 800; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            vtp = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            cv  = ($urandom_range(0, 1) == 1);
            cc  = 2'($urandom_range(0, 3));
            cn  = ($urandom_range(0, 15) == 0);
            drive(st, vtp, cv, cc, cn);
            n_checks++;
            if ({Busy, Due, Paid, Change, Refund, RefundValid, CoinReject} !==
                {e_busy, e_due, e_paid, e_change, e_refund, e_rv, e_reject}) begin
                n_fail++;
                $display("FAIL random_cycle%0d got busy=%b due=%0d paid=%b chg=%0d ref=%0d rv=%b rej=%b want busy=%b due=%0d paid=%b chg=%0d ref=%0d rv=%b rej=%b",
                         i, Busy, Due, Paid, Change, Refund, RefundValid, CoinReject,
                         e_busy, e_due, e_paid, e_change, e_refund, e_rv, e_reject);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact_pay();
        test_change();
        test_cancel_with_coin();
        test_reject();
        test_zero_price();
        test_back_to_back();
        if (TIMEOUT_ON) test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
